// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants for the parametrised synchronous FIFO.
//   DEF_DATA_W  default word width
//   DEF_ADDR_W  default address width (depth = 2**DEF_ADDR_W)
//   fifo_depth  depth in words for a given address width, used to derive the
//               default almost-full threshold
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 8;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port RAM, DATA_W x 2**ADDR_W, one clock, technology-neutral so
// that synthesis can infer and tile block RAM as it sees fit.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata is loaded on the edge that samples re
//   raddr  read address
//   rdata  registered read data (holds when re is low)
// A read and a write to the same address on the same edge return the old word.
// -----------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  // NOTE: the array and its output register carry no reset; a reset branch
  // would stop synthesis from mapping them onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule : sync_fifo_ram

// File: rtl/sync_fifo_p.sv
// -----------------------------------------------------------------------------
// sync_fifo_p
// Parametrised single-clock FIFO on an inferred simple dual-port RAM. All
// 2**ADDR_W entries are usable; occupancy is ADDR_W+1 bits wide.
// Optional feature macro: SYNC_FIFO_ERR_EN
//   defined     -> ovf_o / udf_o are sticky error flags cleared only by reset
//   not defined -> ovf_o / udf_o are tied low, no error logic is built
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   wdata_i    write data
//   wvalid_i   write request, accepted when not full
//   wfull_o    occupancy == depth
//   wafull_o   occupancy >= AFULL_TH
//   read_i     read request, accepted when not empty
//   rdata_o    registered read data, holds between reads
//   rvalid_o   one-cycle pulse per accepted read, two edges after acceptance
//   raempty_o  occupancy <= AEMPTY_TH
//   usedw_o    occupancy, 0..depth
//   ovf_o      sticky overflow
//   udf_o      sticky underflow
// -----------------------------------------------------------------------------
module sync_fifo_p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = fifo_depth(ADDR_W) - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              wvalid_i,
  output logic              wfull_o,
  output logic              wafull_o,
  input  logic              read_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              raempty_o,
  output logic [ADDR_W:0]   usedw_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int              DEPTH     = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_C   = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C  = AEMPTY_TH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   usedw;
  logic [ADDR_W:0]   usedw_nxt;
  logic              wr_acc;
  logic              rd_acc;

  // Read pipeline: accept (edge k) -> RAM read (k+1) -> output register (k+2).
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] ram_q;

  // Flags come straight from registered occupancy, so they are glitch-free
  // relative to the clock and need no extra state.
  assign wfull_o   = (usedw == DEPTH_C);
  assign wafull_o  = (usedw >= AFULL_C);
  assign raempty_o = (usedw <= AEMPTY_C);
  assign usedw_o   = usedw;

  // Full-and-read: the write sees the current full flag and is rejected.
  // Empty-and-write: the read sees zero occupancy and is rejected.
  assign wr_acc = wvalid_i && !wfull_o;
  assign rd_acc = read_i && (usedw != '0);

  // NOTE: every branch of this always_comb assigns usedw_nxt, starting from a
  // default, so no latch can be inferred.
  always_comb begin
    usedw_nxt = usedw;
    unique case ({wr_acc, rd_acc})
      2'b10:   usedw_nxt = usedw + 1'b1;
      2'b01:   usedw_nxt = usedw - 1'b1;
      default: usedw_nxt = usedw;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      usedw     <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      usedw     <= usedw_nxt;
      rd_req_q  <= rd_acc;
      rd_addr_q <= rd_ptr;
      rd_pend_q <= rd_req_q;
      rvalid_o  <= rd_pend_q;
      if (rd_pend_q) rdata_o <= ram_q;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata_i),
    .re    (rd_req_q),
    .raddr (rd_addr_q),
    .rdata (ram_q)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wvalid_i && wfull_o)          ovf_q <= 1'b1;
      if (read_i && (usedw == '0))      udf_q <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif

endmodule : sync_fifo_p

// File: tb/tb_sync_fifo_p.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_p
// Self-checking bench for sync_fifo_p at default parameters (64 x 256,
// AFULL_TH = 252, AEMPTY_TH = 4). A reference model holds the FIFO contents in
// a queue and schedules each accepted read's word for the edge two cycles
// later; every DUT output is compared after every clock edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_p;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 256;
  localparam int AFULL_TH  = DEPTH - 4;
  localparam int AEMPTY_TH = 4;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] wdata_i;
  logic              wvalid_i;
  logic              wfull_o;
  logic              wafull_o;
  logic              read_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic              raempty_o;
  logic [ADDR_W:0]   usedw_o;
  logic              ovf_o;
  logic              udf_o;

  sync_fifo_p dut (
    .clk       (clk),
    .reset     (reset),
    .wdata_i   (wdata_i),
    .wvalid_i  (wvalid_i),
    .wfull_o   (wfull_o),
    .wafull_o  (wafull_o),
    .read_i    (read_i),
    .rdata_o   (rdata_o),
    .rvalid_o  (rvalid_o),
    .raempty_o (raempty_o),
    .usedw_o   (usedw_o),
    .ovf_o     (ovf_o),
    .udf_o     (udf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } out_t;

  logic [DATA_W-1:0] fifo_q [$];
  out_t              sched_q [$];
  logic [DATA_W-1:0] last_rdata;
  logic              m_ovf;
  logic              m_udf;
  int                cyc;
  int                n_checks;
  int                n_err;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock edge: drive inputs, advance model, compare every output.
  task automatic step(input logic w, input logic [DATA_W-1:0] d,
                      input logic r, input logic rst);
    bit   wr_ok;
    bit   rd_ok;
    bit   exp_rv;
    out_t o;
    wvalid_i = w;
    wdata_i  = d;
    read_i   = r;
    reset    = rst;
    wr_ok = w && (fifo_q.size() < DEPTH);
    rd_ok = r && (fifo_q.size() != 0);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      fifo_q.delete();
      sched_q.delete();
      last_rdata = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && fifo_q.size() == DEPTH) m_ovf = 1'b1;
      if (r && fifo_q.size() == 0)     m_udf = 1'b1;
      if (rd_ok) begin
        o.due  = cyc + 2;
        o.data = fifo_q.pop_front();
        sched_q.push_back(o);
      end
      if (wr_ok) fifo_q.push_back(d);
    end
    exp_rv = (sched_q.size() != 0) && (sched_q[0].due == cyc);
    if (exp_rv) last_rdata = sched_q.pop_front().data;
    check("rvalid",  DATA_W'(rvalid_o),  DATA_W'(exp_rv));
    check("rdata",   rdata_o,            last_rdata);
    check("usedw",   DATA_W'(usedw_o),   DATA_W'(fifo_q.size()));
    check("wfull",   DATA_W'(wfull_o),   DATA_W'(fifo_q.size() == DEPTH));
    check("wafull",  DATA_W'(wafull_o),  DATA_W'(fifo_q.size() >= AFULL_TH));
    check("raempty", DATA_W'(raempty_o), DATA_W'(fifo_q.size() <= AEMPTY_TH));
`ifdef SYNC_FIFO_ERR_EN
    check("ovf", DATA_W'(ovf_o), DATA_W'(m_ovf));
    check("udf", DATA_W'(udf_o), DATA_W'(m_udf));
`else
    check("ovf", DATA_W'(ovf_o), '0);
    check("udf", DATA_W'(udf_o), '0);
`endif
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int rv_seen;
    n_checks   = 0;
    n_err      = 0;
    cyc        = 0;
    last_rdata = '0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
    reset      = 1'b1;
    wvalid_i   = 1'b0;
    read_i     = 1'b0;
    wdata_i    = '0;

    // Reset values.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Write 1..5, read five cycles, then let the pipeline drain.
    for (int i = 1; i <= 5; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  step(1'b0, '0, 1'b0, 1'b0);
    check("burst_last_rdata", rdata_o, 64'h5);

    // Fill to 256, then one rejected write (overflow).
    for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b0, 1'b0);
    check("full_usedw", DATA_W'(usedw_o), DATA_W'(DEPTH));
    step(1'b1, rnd(), 1'b0, 1'b0);

    // Full with read+write: read wins; the next write refills.
    step(1'b1, rnd(), 1'b1, 1'b0);
    check("full_rw_usedw", DATA_W'(usedw_o), DATA_W'(DEPTH - 1));
    step(1'b1, rnd(), 1'b0, 1'b0);
    check("refill_usedw", DATA_W'(usedw_o), DATA_W'(DEPTH));

    // Drain completely.
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)     step(1'b0, '0, 1'b0, 1'b0);

    // Empty with read+write: write wins, read rejected (underflow).
    step(1'b1, rnd(), 1'b1, 1'b0);
    check("empty_rw_usedw", DATA_W'(usedw_o), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

    // Steady state at occupancy 10 for 1000 cycles of simultaneous traffic.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)   step(1'b1, rnd(), 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b1, rnd(), 1'b1, 1'b0);
    check("steady_usedw", DATA_W'(usedw_o), 64'd10);

    // Random mixed traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)), 1'b0);

    // Reset one cycle after an accepted read: no rvalid afterwards.
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (rvalid_o) rv_seen++;
    end
    check("post_reset_rvalid", DATA_W'(rv_seen), '0);
    check("post_reset_rdata", rdata_o, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_sync_fifo_p
